// File: rtl/fpu_add_sched_pkg.sv
// Shared types and constants for the FP16 adder scheduler.
package fpu_add_sched_pkg;

    localparam int unsigned FP16_W = 16;

    typedef logic [FP16_W-1:0] fp16_t;

    // Quiet NaN pattern the adder itself produces; reused for watchdog results.
    localparam fp16_t FP16_QNAN = 16'hFE00;

    typedef enum logic [2:0] {
        RST_WAIT,
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_Z,
        RESP
    } sched_state_t;

    // Counter/index width for values 0..n-1, never below one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fpu_add_sched_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr, wrapping.
module rr_pick
    import fpu_add_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = cnt_w(NREQ)
) (
    input  logic [NREQ-1:0] req_stb,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_vld
);

    int unsigned idx;

    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr) + k) % NREQ;
            if (!grant_vld && req_stb[IW'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fpu_add_sched.sv
// Round-robin scheduler sharing one adder16 ack/strobe core between NREQ requesters,
// with a WAIT_Z watchdog that substitutes a NaN result and re-resets the adder.
module fpu_add_sched
    import fpu_add_sched_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned RST_HOLD = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_stb,
    input  logic [FP16_W*NREQ-1:0] req_a,
    input  logic [FP16_W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]        req_ack,
    output logic [NREQ-1:0]        rsp_stb,
    output logic [FP16_W-1:0]      rsp_z,
    output logic                   rsp_err,
    input  logic [NREQ-1:0]        rsp_ack,
    output logic                   add_rst,
    output logic [FP16_W-1:0]      add_a,
    output logic [FP16_W-1:0]      add_b,
    input  logic                   add_a_ack,
    input  logic                   add_b_ack,
    input  logic [FP16_W-1:0]      add_z,
    input  logic                   add_z_stb,
    output logic                   add_z_ack
);

    localparam int unsigned IW = cnt_w(NREQ);
    localparam int unsigned HW = cnt_w(RST_HOLD + 1);
    localparam int unsigned WW = cnt_w(TIMEOUT);

    sched_state_t  state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] g;
    logic [IW-1:0] grant_idx;
    logic          grant_vld;
    logic [HW-1:0] hold_cnt;
    logic [WW-1:0] wd_cnt;
    fp16_t         sel_a;
    fp16_t         sel_b;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_stb   (req_stb),
        .rr_ptr    (rr_ptr),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IW'(k) == grant_idx) begin
                sel_a = req_a[k*FP16_W +: FP16_W];
                sel_b = req_b[k*FP16_W +: FP16_W];
            end
        end
    end

    assign add_z_ack = (state == WAIT_Z);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RST_WAIT;
            hold_cnt <= HW'(RST_HOLD);
            add_rst  <= 1'b1;
            req_ack  <= '0;
            rsp_stb  <= '0;
            rsp_err  <= 1'b0;
            rsp_z    <= '0;
            add_a    <= '0;
            add_b    <= '0;
            rr_ptr   <= '0;
            g        <= '0;
            wd_cnt   <= '0;
        end else begin
            req_ack <= '0;

            // The adder reset countdown runs in whatever state we are in, so a
            // watchdog event overlaps its hold time with the RESP handshake.
            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
                if (hold_cnt == HW'(1)) begin
                    add_rst <= 1'b0;
                end
            end

            case (state)
                RST_WAIT: begin
                    if (hold_cnt <= HW'(1)) begin
                        add_rst <= 1'b0;
                        state   <= IDLE;
                    end
                end

                IDLE: begin
                    if (grant_vld) begin
                        add_a              <= sel_a;
                        add_b              <= sel_b;
                        g                  <= grant_idx;
                        req_ack[grant_idx] <= 1'b1;
                        state              <= SEND_A;
                    end
                end

                SEND_A: begin
                    if (add_a_ack) begin
                        state <= SEND_B;
                    end
                end

                SEND_B: begin
                    if (add_b_ack) begin
                        wd_cnt <= '0;
                        state  <= WAIT_Z;
                    end
                end

                WAIT_Z: begin
                    if (add_z_stb && add_z_ack) begin
                        rsp_z      <= add_z;
                        rsp_err    <= 1'b0;
                        rsp_stb    <= '0;
                        rsp_stb[g] <= 1'b1;
                        state      <= RESP;
                    end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
                        rsp_z      <= FP16_QNAN;
                        rsp_err    <= 1'b1;
                        hold_cnt   <= HW'(RST_HOLD);
                        add_rst    <= (RST_HOLD != 0);
                        rsp_stb    <= '0;
                        rsp_stb[g] <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + WW'(1);
                    end
                end

                RESP: begin
                    if (rsp_ack[g]) begin
                        rsp_stb <= '0;
                        rr_ptr  <= (g == IW'(NREQ - 1)) ? '0 : g + IW'(1);
                        state   <= (hold_cnt > HW'(1)) ? RST_WAIT : IDLE;
                    end
                end

                default: state <= RST_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_add_sched.sv
// Directed bench for fpu_add_sched with a cycle-level adder16 handshake model.
module tb_fpu_add_sched;

    localparam int NREQ = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_stb = '0;
    logic [16*NREQ-1:0]   req_a = '0;
    logic [16*NREQ-1:0]   req_b = '0;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ-1:0]      rsp_stb;
    logic [15:0]          rsp_z;
    logic                 rsp_err;
    logic [NREQ-1:0]      rsp_ack = '0;
    logic                 add_rst;
    logic [15:0]          add_a;
    logic [15:0]          add_b;
    logic                 add_z_ack;

    logic        m_a_ack = 1'b0;
    logic        m_b_ack = 1'b0;
    logic        m_z_stb = 1'b0;
    logic [15:0] m_z = '0;
    logic [15:0] ma = '0;
    logic [15:0] mb = '0;
    int          mstate = 0;
    logic        mc = 1'b0;
    logic        stall = 1'b0;

    int errors = 0;
    int checks = 0;

    fpu_add_sched #(.NREQ(NREQ), .TIMEOUT(64), .RST_HOLD(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_stb   (req_stb),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ack   (req_ack),
        .rsp_stb   (rsp_stb),
        .rsp_z     (rsp_z),
        .rsp_err   (rsp_err),
        .rsp_ack   (rsp_ack),
        .add_rst   (add_rst),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_a_ack (m_a_ack),
        .add_b_ack (m_b_ack),
        .add_z     (m_z),
        .add_z_stb (m_z_stb),
        .add_z_ack (add_z_ack)
    );

    always #5 clk = ~clk;

    // Known FP16 sums for the operand pairs used here.
    function automatic logic [15:0] fp_sum(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3C00_3C00: return 16'h4000;
            32'h3C00_BC00: return 16'h0000;
            32'h7C00_3C00: return 16'h7C00;
            32'h7E00_3C00: return 16'hFE00;
            32'h4000_3C00: return 16'h4200;
            32'h4000_4000: return 16'h4400;
            32'h4400_3C00: return 16'h4500;
            default:       return 16'hDEAD;
        endcase
    endfunction

    // Adder model: ack held two cycles per operand, capture on the second.
    always @(posedge clk) begin
        if (add_rst) begin
            mstate  <= 0;
            m_a_ack <= 1'b0;
            m_b_ack <= 1'b0;
            m_z_stb <= 1'b0;
            mc      <= 1'b0;
        end else begin
            case (mstate)
                0: if (|req_ack) begin m_a_ack <= 1'b1; mc <= 1'b0; mstate <= 1; end
                1: if (mc) begin ma <= add_a; m_a_ack <= 1'b0; m_b_ack <= 1'b1; mc <= 1'b0; mstate <= 2; end
                   else mc <= 1'b1;
                2: if (mc) begin mb <= add_b; m_b_ack <= 1'b0; mc <= 1'b0; mstate <= 3; end
                   else mc <= 1'b1;
                3: if (!stall) begin m_z <= fp_sum(ma, mb); m_z_stb <= 1'b1; mstate <= 4; end
                4: if (m_z_stb && add_z_ack) begin m_z_stb <= 1'b0; mstate <= 0; end
                default: mstate <= 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [15:0] a, input logic [15:0] b);
        req_a[16*idx +: 16] = a;
        req_b[16*idx +: 16] = b;
        req_stb[idx]        = 1'b1;
    endtask

    // Called at the negedge where rsp_stb is seen; acks it and counts add_rst cycles.
    task automatic finish_rsp(input int idx, input string name, output int rst_cycles);
        int n;
        rsp_ack[idx] = 1'b1;
        rst_cycles = add_rst ? 1 : 0;
        @(negedge clk);
        rsp_ack[idx] = 1'b0;
        chk({name, " rsp_stb_clear"}, 32'(rsp_stb), 32'h0);
        n = 0;
        while (add_rst && n < 20) begin
            rst_cycles++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic issue(input int idx, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] z, output logic err, output logic [NREQ-1:0] stb,
                         output int zack, output int acks);
        int n;
        zack = 0;
        acks = 0;
        @(negedge clk);
        set_req(idx, a, b);
        n = 0;
        while (!req_ack[idx] && n < 40) begin @(negedge clk); n++; end
        if (req_ack[idx]) acks++;
        req_stb[idx] = 1'b0;
        @(negedge clk);
        n = 0;
        while (rsp_stb == '0 && n < 400) begin
            if (add_z_ack) zack++;
            if (req_ack[idx]) acks++;
            @(negedge clk);
            n++;
        end
        z   = rsp_z;
        err = rsp_err;
        stb = rsp_stb;
    endtask

    // Serves whichever request is next granted among already-raised requests.
    task automatic serve(input int exp_idx, input logic [15:0] exp_z, input bit drop, input string name);
        int n;
        int rc;
        n = 0;
        while (req_ack == '0 && n < 40) begin @(negedge clk); n++; end
        chk({name, " grant"}, 32'(req_ack), 32'(1 << exp_idx));
        chk({name, " grant_latency"}, 32'(n), 32'd1);
        if (drop) req_stb[exp_idx] = 1'b0;
        @(negedge clk);
        n = 0;
        while (rsp_stb == '0 && n < 400) begin @(negedge clk); n++; end
        chk({name, " rsp_latency"}, 32'(n), 32'd6);
        chk({name, " rsp_stb"}, 32'(rsp_stb), 32'(1 << exp_idx));
        chk({name, " rsp_z"}, 32'(rsp_z), 32'(exp_z));
        finish_rsp(exp_idx, name, rc);
    endtask

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] z;
        logic        err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [15:0]     z;
        logic            err;
        logic [NREQ-1:0] stb;
        int              zack;
        int              acks;
        int              rc;
        int              n;

        vecs[0] = '{idx: 1, a: 16'h3C00, b: 16'h3C00, z: 16'h4000, err: 1'b0};
        vecs[1] = '{idx: 0, a: 16'h3C00, b: 16'hBC00, z: 16'h0000, err: 1'b0};
        vecs[2] = '{idx: 2, a: 16'h7C00, b: 16'h3C00, z: 16'h7C00, err: 1'b0};
        vecs[3] = '{idx: 1, a: 16'h4000, b: 16'h3C00, z: 16'h4200, err: 1'b0};
        vecs[4] = '{idx: 3, a: 16'h7E00, b: 16'h3C00, z: 16'hFE00, err: 1'b0};

        #1 rst = 1'b0;
        #2;
        chk("rst add_rst", 32'(add_rst), 32'h1);
        chk("rst req_ack", 32'(req_ack), 32'h0);
        chk("rst rsp_stb", 32'(rsp_stb), 32'h0);
        chk("rst rsp_err", 32'(rsp_err), 32'h0);
        chk("rst rsp_z", 32'(rsp_z), 32'h0);
        chk("rst add_a", 32'(add_a), 32'h0);
        chk("rst add_b", 32'(add_b), 32'h0);
        chk("rst add_z_ack", 32'(add_z_ack), 32'h0);

        repeat (3) @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (add_rst && n < 10) begin n++; @(negedge clk); end
        chk("release add_rst_cycles", 32'(n), 32'd2);

        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].idx, vecs[i].a, vecs[i].b, z, err, stb, zack, acks);
            chk($sformatf("vec%0d req_ack_pulses", i), 32'(acks), 32'd1);
            chk($sformatf("vec%0d rsp_stb", i), 32'(stb), 32'(1 << vecs[i].idx));
            chk($sformatf("vec%0d rsp_z", i), 32'(z), 32'(vecs[i].z));
            chk($sformatf("vec%0d rsp_err", i), 32'(err), 32'(vecs[i].err));
            if (i == 3) begin
                // rsp_ack on a non-granted index must not retire the response
                rsp_ack[0] = 1'b1;
                @(negedge clk);
                rsp_ack[0] = 1'b0;
                chk("stray_ack rsp_stb_held", 32'(rsp_stb), 32'(1 << vecs[i].idx));
            end
            finish_rsp(vecs[i].idx, $sformatf("vec%0d", i), rc);
            chk($sformatf("vec%0d add_rst_after", i), 32'(rc), 32'd0);
        end

        stall = 1'b1;
        issue(2, 16'h3C00, 16'h3C00, z, err, stb, zack, acks);
        stall = 1'b0;
        chk("wd wait_z_cycles", 32'(zack), 32'd64);
        chk("wd rsp_stb", 32'(stb), 32'h4);
        chk("wd rsp_z", 32'(z), 32'hFE00);
        chk("wd rsp_err", 32'(err), 32'h1);
        finish_rsp(2, "wd", rc);
        chk("wd add_rst_cycles", 32'(rc), 32'd2);

        issue(3, 16'h4000, 16'h3C00, z, err, stb, zack, acks);
        chk("post_wd rsp_z", 32'(z), 32'h4200);
        chk("post_wd rsp_err", 32'(err), 32'h0);
        finish_rsp(3, "post_wd", rc);

        @(negedge clk);
        set_req(0, 16'h3C00, 16'h3C00);
        set_req(1, 16'h4000, 16'h3C00);
        set_req(2, 16'h4000, 16'h4000);
        set_req(3, 16'h4400, 16'h3C00);
        serve(0, 16'h4000, 1'b1, "rr0");
        serve(1, 16'h4200, 1'b1, "rr1");
        serve(2, 16'h4400, 1'b1, "rr2");
        serve(3, 16'h4500, 1'b1, "rr3");

        @(negedge clk);
        set_req(0, 16'h3C00, 16'h3C00);
        set_req(2, 16'h4000, 16'h4000);
        serve(0, 16'h4000, 1'b0, "fair0");
        serve(2, 16'h4400, 1'b1, "fair2");
        serve(0, 16'h4000, 1'b1, "fair0b");

        stall = 1'b1;
        @(negedge clk);
        set_req(1, 16'h3C00, 16'h3C00);
        n = 0;
        while (!req_ack[1] && n < 40) begin @(negedge clk); n++; end
        req_stb[1] = 1'b0;
        n = 0;
        while (!add_z_ack && n < 40) begin @(negedge clk); n++; end
        chk("midrst in_wait_z", 32'(add_z_ack), 32'h1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst add_rst", 32'(add_rst), 32'h1);
        chk("midrst rsp_stb", 32'(rsp_stb), 32'h0);
        chk("midrst rsp_z", 32'(rsp_z), 32'h0);
        chk("midrst add_a", 32'(add_a), 32'h0);
        chk("midrst add_z_ack", 32'(add_z_ack), 32'h0);
        stall = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst no_rsp", 32'(rsp_stb), 32'h0);
        rst = 1'b1;
        issue(1, 16'h3C00, 16'h3C00, z, err, stb, zack, acks);
        chk("reissue rsp_stb", 32'(stb), 32'h2);
        chk("reissue rsp_z", 32'(z), 32'h4000);
        chk("reissue rsp_err", 32'(err), 32'h0);
        finish_rsp(1, "reissue", rc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
